// File: rtl/wbuart_fifo_bridge.sv
// rtl/wbuart_fifo_bridge.sv - Wishbone UART front-end with RX/TX FIFOs and loader/bus mode switch
//
// Sits between the byte-level uart_rx/uart_tx serializers and two clients:
// the hex loader (byte strobes) and the CPU (pipelined Wishbone slave).
// In LOADER mode received bytes go straight to the loader; in BUS mode they
// are queued in the RX FIFO for the CPU. The TX FIFO is fed from either side
// and drained to uart_tx by a small handshake FSM.
//
// Register map (word addresses from BASE_ADDR):
//   +0 DATA   rd: {23'b0, rx_empty, rx head byte} (pops)   wr: push [7:0] to TX FIFO
//   +1 CTRL   rd: status/counts                            wr: [0] mode, [1] flush, [2] clear flags
//   +2 ID     rd: {24'b0, FIFO_AW}
//
// Ports:
//   i_clk, i_reset                  clock, asynchronous active-high reset
//   i_rx_data, i_rx_stb             byte from uart_rx
//   o_tx_data, o_tx_stb, i_tx_busy  byte to uart_tx and its busy flag
//   o_ldr_rx_data, o_ldr_rx_stb     byte to the loader (LOADER mode only)
//   i_ldr_tx_data, i_ldr_tx_stb     loader reply byte (LOADER mode only)
//   o_ldr_tx_busy                   TX FIFO full
//   o_ldr_reset                     loader held in reset (reset or BUS mode)
//   i_wb_*, o_wb_*                  Wishbone slave, ack one cycle after each request
//   o_device_sel                    address decode of this block
//
// Optional build macro WBUART_IRQ_EN adds o_irq and CTRL write bit [3]
// (interrupt enable, readable at status bit [7]).

module wbuart_fifo_bridge #(
  parameter int unsigned FIFO_AW    = 4,
  parameter logic [29:0] BASE_ADDR  = 30'h3FFF_FFFC,
  parameter logic        RESET_MODE = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_stb,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_stb,
  input  logic        i_tx_busy,
  output logic [7:0]  o_ldr_rx_data,
  output logic        o_ldr_rx_stb,
  input  logic [7:0]  i_ldr_tx_data,
  input  logic        i_ldr_tx_stb,
  output logic        o_ldr_tx_busy,
  output logic        o_ldr_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        o_device_sel
`ifdef WBUART_IRQ_EN
  ,output logic       o_irq
`endif
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]      CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_STB,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_e;

  // ---------------------------------------------------------------------------
  // Wishbone decode
  // ---------------------------------------------------------------------------
  logic        wb_req;
  logic        in_range;
  logic [29:0] offset;
  logic        sel_data;
  logic        sel_ctrl;
  logic        data_rd;
  logic        data_wr;
  logic        ctrl_wr;

  assign wb_req   = i_wb_cyc && i_wb_stb;
  // Compare one bit wider so BASE_ADDR+2 cannot wrap at the top of the space.
  assign in_range = ({1'b0, i_wb_addr} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, i_wb_addr} <= ({1'b0, BASE_ADDR} + 31'd2));
  assign offset   = i_wb_addr - BASE_ADDR;
  assign sel_data = in_range && (offset[1:0] == 2'd0);
  assign sel_ctrl = in_range && (offset[1:0] == 2'd1);
  assign data_rd  = wb_req && !i_wb_we && sel_data;
  assign data_wr  = wb_req &&  i_wb_we && sel_data;
  assign ctrl_wr  = wb_req &&  i_wb_we && sel_ctrl;

  assign o_device_sel = i_wb_cyc && in_range;
  assign o_wb_stall   = 1'b0;

  // ---------------------------------------------------------------------------
  // Mode and control
  // ---------------------------------------------------------------------------
  logic mode_q, mode_d;
  logic to_bus;
  logic flush_all;
  logic clr_flags;

  assign mode_d      = ctrl_wr ? i_wb_data[0] : mode_q;
  assign to_bus      = ctrl_wr && i_wb_data[0] && !mode_q;
  assign flush_all   = ctrl_wr && i_wb_data[1];
  assign clr_flags   = ctrl_wr && i_wb_data[2];
  assign o_ldr_reset = i_reset || mode_q;

  // ---------------------------------------------------------------------------
  // RX FIFO (BUS mode only)
  // ---------------------------------------------------------------------------
  logic [7:0]         rx_mem_q [DEPTH];
  logic [FIFO_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
  logic               rx_empty, rx_full;
  logic               rx_push_req, rx_push, rx_pop, rx_flush;
  logic               rx_ovr_q, rx_ovr_d;
  logic [7:0]         rx_head;

  assign rx_empty    = (rx_cnt_q == '0);
  assign rx_full     = (rx_cnt_q == CNT_FULL);
  assign rx_push_req = mode_q && i_rx_stb;
  assign rx_pop      = data_rd && !rx_empty;
  assign rx_flush    = flush_all || to_bus;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign rx_head     = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
  assign rx_ovr_d    = (rx_push_req && rx_full && !rx_pop && !rx_flush) ||
                       (rx_ovr_q && !clr_flags);

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + PTR_ONE;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_ONE;
      rx_cnt_d = rx_cnt_q + (rx_push ? CNT_ONE : '0) - (rx_pop ? CNT_ONE : '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (rx_push && !rx_flush) rx_mem_q[rx_wptr_q] <= i_rx_data;
  end

  // ---------------------------------------------------------------------------
  // TX FIFO (bus writes in any mode, loader replies in LOADER mode)
  // ---------------------------------------------------------------------------
  logic [7:0]         tx_mem_q [DEPTH];
  logic [FIFO_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
  logic               tx_empty, tx_full;
  logic               tx_ldr_push, tx_push_req, tx_push, tx_pop, tx_flush;
  logic [7:0]         tx_wdata;
  logic               tx_ovf_q, tx_ovf_d;
  logic               tx_fire;

  assign tx_empty    = (tx_cnt_q == '0);
  assign tx_full     = (tx_cnt_q == CNT_FULL);
  assign tx_ldr_push = !mode_q && i_ldr_tx_stb;
  assign tx_push_req = data_wr || tx_ldr_push;
  assign tx_push     = tx_push_req && !tx_full;
  // Bus write has priority; a colliding loader byte is lost and flagged.
  assign tx_wdata    = data_wr ? i_wb_data[7:0] : i_ldr_tx_data;
  assign tx_pop      = tx_fire;
  assign tx_flush    = flush_all;
  assign tx_ovf_d    = (tx_push_req && tx_full) || (data_wr && tx_ldr_push) ||
                       (tx_ovf_q && !clr_flags);
  assign o_ldr_tx_busy = tx_full;

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + PTR_ONE;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_ONE;
      tx_cnt_d = tx_cnt_q + (tx_push ? CNT_ONE : '0) - (tx_pop ? CNT_ONE : '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (tx_push && !tx_flush) tx_mem_q[tx_wptr_q] <= tx_wdata;
  end

  // ---------------------------------------------------------------------------
  // TX drain FSM: strobe, then wait for uart_tx busy to rise and fall
  // ---------------------------------------------------------------------------
  tx_state_e tx_state_q, tx_state_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_fire    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !i_tx_busy) tx_state_d = TX_STB;
      end
      TX_STB: begin
        // Re-qualify: a flush or an unexpected busy cancels the strobe.
        if (!tx_empty && !i_tx_busy) begin
          tx_fire    = 1'b1;
          tx_state_d = TX_WAIT_HI;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_WAIT_HI: begin
        if (i_tx_busy) tx_state_d = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        if (!i_tx_busy) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign o_tx_stb  = tx_fire;
  assign o_tx_data = tx_fire ? tx_mem_q[tx_rptr_q] : 8'h00;

  // ---------------------------------------------------------------------------
  // Optional interrupt
  // ---------------------------------------------------------------------------
  logic irq_en_bit;

`ifdef WBUART_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  assign irq_en_d   = ctrl_wr ? i_wb_data[3] : irq_en_q;
  assign irq_d      = irq_en_q && (((rx_cnt_q != '0) && mode_q) || rx_ovr_q || tx_ovf_q);
  assign irq_en_bit = irq_en_q;
  assign o_irq      = irq_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end
`else
  assign irq_en_bit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux and registered bus/loader outputs
  // ---------------------------------------------------------------------------
  logic [31:0] status_word;
  logic [31:0] rd_val;
  logic        wb_ack_q, wb_ack_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        ldr_stb_q, ldr_stb_d;
  logic [7:0]  ldr_data_q, ldr_data_d;

  assign status_word = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q),
                        irq_en_bit, tx_ovf_q, rx_ovr_q, tx_full, tx_empty,
                        rx_full, rx_empty, mode_q};

  always_comb begin
    rd_val = 32'h0;
    if (in_range) begin
      case (offset[1:0])
        2'd0:    rd_val = {23'h0, rx_empty, rx_head};
        2'd1:    rd_val = status_word;
        2'd2:    rd_val = {24'h0, 8'(FIFO_AW)};
        default: rd_val = 32'h0;
      endcase
    end
  end

  assign wb_ack_d   = wb_req;
  assign wb_data_d  = (wb_req && !i_wb_we) ? rd_val : wb_data_q;
  assign ldr_stb_d  = !mode_q && i_rx_stb;
  assign ldr_data_d = ldr_stb_d ? i_rx_data : ldr_data_q;

  assign o_wb_ack      = wb_ack_q;
  assign o_wb_data     = wb_data_q;
  assign o_ldr_rx_stb  = ldr_stb_q;
  assign o_ldr_rx_data = ldr_data_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mode_q     <= RESET_MODE;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      rx_ovr_q   <= 1'b0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      tx_ovf_q   <= 1'b0;
      tx_state_q <= TX_IDLE;
      wb_ack_q   <= 1'b0;
      wb_data_q  <= 32'h0;
      ldr_stb_q  <= 1'b0;
      ldr_data_q <= 8'h00;
    end else begin
      mode_q     <= mode_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_ovf_q   <= tx_ovf_d;
      tx_state_q <= tx_state_d;
      wb_ack_q   <= wb_ack_d;
      wb_data_q  <= wb_data_d;
      ldr_stb_q  <= ldr_stb_d;
      ldr_data_q <= ldr_data_d;
    end
  end

  // Upper write-data bits and high offset bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{i_wb_data, offset};

endmodule

// File: tb/tb_wbuart_fifo_bridge.sv
// tb/tb_wbuart_fifo_bridge.sv - directed bench for wbuart_fifo_bridge (default and small-FIFO/BUS-reset instances)

module tb_wbuart_fifo_bridge;

  localparam logic [29:0] BASE = 30'h3FFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_stb;
  logic        tx_busy;
  logic [7:0]  ldr_tx_data;
  logic        ldr_tx_stb;
  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_addr;
  logic [31:0] wb_wdata;

  logic [7:0]  a_tx_data, a_ldr_rx_data, b_tx_data, b_ldr_rx_data;
  logic        a_tx_stb, a_ldr_rx_stb, a_ldr_tx_busy, a_ldr_reset, a_ack, a_stall, a_sel;
  logic        b_tx_stb, b_ldr_rx_stb, b_ldr_tx_busy, b_ldr_reset, b_ack, b_stall, b_sel;
  logic [31:0] a_rdata, b_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ra, rb;
  logic        ack_ok, sel_seen;

  always #5 clk = ~clk;

  wbuart_fifo_bridge dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_stb(rx_stb),
    .o_tx_data(a_tx_data), .o_tx_stb(a_tx_stb), .i_tx_busy(tx_busy),
    .o_ldr_rx_data(a_ldr_rx_data), .o_ldr_rx_stb(a_ldr_rx_stb),
    .i_ldr_tx_data(ldr_tx_data), .i_ldr_tx_stb(ldr_tx_stb),
    .o_ldr_tx_busy(a_ldr_tx_busy), .o_ldr_reset(a_ldr_reset),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_addr(wb_addr),
    .i_wb_data(wb_wdata), .o_wb_ack(a_ack), .o_wb_stall(a_stall),
    .o_wb_data(a_rdata), .o_device_sel(a_sel)
  );

  wbuart_fifo_bridge #(.FIFO_AW(2), .RESET_MODE(1'b1)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_stb(rx_stb),
    .o_tx_data(b_tx_data), .o_tx_stb(b_tx_stb), .i_tx_busy(tx_busy),
    .o_ldr_rx_data(b_ldr_rx_data), .o_ldr_rx_stb(b_ldr_rx_stb),
    .i_ldr_tx_data(ldr_tx_data), .i_ldr_tx_stb(ldr_tx_stb),
    .o_ldr_tx_busy(b_ldr_tx_busy), .o_ldr_reset(b_ldr_reset),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_addr(wb_addr),
    .i_wb_data(wb_wdata), .o_wb_ack(b_ack), .o_wb_stall(b_stall),
    .o_wb_data(b_rdata), .o_device_sel(b_sel)
  );

  task automatic clear_inputs();
    rx_data = 8'h00; rx_stb = 1'b0; tx_busy = 1'b0;
    ldr_tx_data = 8'h00; ldr_tx_stb = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_wdata = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One Wishbone request; reports read data of both instances, whether ack was
  // low during the request cycle and high exactly one cycle later, and the
  // device select seen during the request.
  task automatic wb_xfer(input logic we, input logic [29:0] addr, input logic [31:0] wdat,
                         output logic [31:0] rd_a, output logic [31:0] rd_b,
                         output logic ok, output logic sel);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = wdat;
    #1;
    sel = a_sel;
    ok  = !a_ack && !b_ack;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    ok   = ok && a_ack && b_ack;
    rd_a = a_rdata;
    rd_b = b_rdata;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    rx_stb = 1'b1; rx_data = b;
    @(negedge clk);
    rx_stb = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk); @(negedge clk);
    checks++; if (a_tx_stb !== 1'b0) begin errors++; $display("FAIL reset_tx_stb: got %b expected 0", a_tx_stb); end
    checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", a_ack); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", a_rdata); end
    checks++; if (a_ldr_rx_stb !== 1'b0) begin errors++; $display("FAIL reset_ldr_rx_stb: got %b expected 0", a_ldr_rx_stb); end
    checks++; if (a_ldr_reset !== 1'b1) begin errors++; $display("FAIL reset_ldr_reset_a: got %b expected 1", a_ldr_reset); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", a_stall); end
    rst = 1'b0;
    #1;
    checks++; if (a_ldr_reset !== 1'b0) begin errors++; $display("FAIL ldr_reset_loader_mode: got %b expected 0", a_ldr_reset); end
    checks++; if (b_ldr_reset !== 1'b1) begin errors++; $display("FAIL ldr_reset_bus_mode: got %b expected 1", b_ldr_reset); end
    wb_xfer(1'b0, BASE + 30'd1, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (ra !== 32'h0000_000A) begin errors++; $display("FAIL reset_status_a: got %h expected 0000000a", ra); end
    checks++; if (rb !== 32'h0000_000B) begin errors++; $display("FAIL reset_status_b: got %h expected 0000000b", rb); end
    checks++; if (ack_ok !== 1'b1 || sel_seen !== 1'b1) begin errors++; $display("FAIL status_ack_sel: got ack_ok=%b sel=%b expected 1 1", ack_ok, sel_seen); end
    wb_xfer(1'b0, BASE + 30'd2, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (ra !== 32'h4 || rb !== 32'h2) begin errors++; $display("FAIL id_reg: got %h/%h expected 4/2", ra, rb); end
  endtask

  task automatic test_loader_forward();
    apply_reset();
    @(negedge clk);
    rx_stb = 1'b1; rx_data = 8'h3A;
    @(negedge clk);
    rx_stb = 1'b0;
    checks++; if (a_ldr_rx_stb !== 1'b1 || a_ldr_rx_data !== 8'h3A) begin errors++; $display("FAIL ldr_forward: got stb=%b data=%h expected 1 3a", a_ldr_rx_stb, a_ldr_rx_data); end
    @(negedge clk);
    checks++; if (a_ldr_rx_stb !== 1'b0) begin errors++; $display("FAIL ldr_stb_one_cycle: got %b expected 0", a_ldr_rx_stb); end
    wb_xfer(1'b0, BASE + 30'd1, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (ra !== 32'h0000_000A) begin errors++; $display("FAIL ldr_status_a: got %h expected 0000000a", ra); end
    checks++; if (rb !== 32'h0000_0109) begin errors++; $display("FAIL bus_rx_queued_b: got %h expected 00000109", rb); end
  endtask

  task automatic test_bus_fifo();
    logic [31:0] exp;
    apply_reset();
    wb_xfer(1'b1, BASE + 30'd1, 32'h1, ra, rb, ack_ok, sel_seen);
    for (int i = 1; i <= 5; i++) rx_byte(8'(i));
    checks++; if (a_ldr_rx_stb !== 1'b0) begin errors++; $display("FAIL bus_no_ldr_stb: got %b expected 0", a_ldr_rx_stb); end
    for (int k = 0; k < 6; k++) begin
      exp = (k < 5) ? 32'(k + 1) : 32'h100;
      wb_xfer(1'b0, BASE, 32'h0, ra, rb, ack_ok, sel_seen);
      checks++; if (ra !== exp) begin errors++; $display("FAIL rx_read_%0d: got %h expected %h", k, ra, exp); end
      checks++; if (ack_ok !== 1'b1) begin errors++; $display("FAIL rx_read_ack_%0d: got %b expected 1", k, ack_ok); end
    end
    wb_xfer(1'b0, BASE + 30'd1, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (ra !== 32'h0000_000B) begin errors++; $display("FAIL bus_status_a: got %h expected 0000000b", ra); end
  endtask

  task automatic test_overflow_and_same_cycle();
    logic [7:0] exp_bytes [4];
    exp_bytes = '{8'h02, 8'h03, 8'h04, 8'h77};
    apply_reset();
    for (int i = 1; i <= 5; i++) rx_byte(8'(i));
    wb_xfer(1'b0, BASE + 30'd1, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (rb !== 32'h0000_042D) begin errors++; $display("FAIL rx_overflow_status: got %h expected 0000042d", rb); end
    wb_xfer(1'b1, BASE + 30'd1, 32'h5, ra, rb, ack_ok, sel_seen);
    wb_xfer(1'b0, BASE + 30'd1, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (rb !== 32'h0000_040D) begin errors++; $display("FAIL flag_clear_status: got %h expected 0000040d", rb); end
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = BASE;
    rx_stb = 1'b1; rx_data = 8'h77;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; rx_stb = 1'b0;
    checks++; if (b_ack !== 1'b1 || b_rdata !== 32'h0000_0001) begin errors++; $display("FAIL full_push_pop_read: got ack=%b data=%h expected 1 00000001", b_ack, b_rdata); end
    wb_xfer(1'b0, BASE + 30'd1, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (rb !== 32'h0000_040D) begin errors++; $display("FAIL full_push_pop_status: got %h expected 0000040d", rb); end
    for (int k = 0; k < 4; k++) begin
      wb_xfer(1'b0, BASE, 32'h0, ra, rb, ack_ok, sel_seen);
      checks++; if (rb !== {24'h0, exp_bytes[k]}) begin errors++; $display("FAIL wrap_read_%0d: got %h expected %h", k, rb, exp_bytes[k]); end
    end
  endtask

  task automatic test_tx_stream();
    int pend = 0;
    int nstb = 0;
    int last = -100;
    logic [7:0] got [2];
    got = '{8'h00, 8'h00};
    apply_reset();
    tx_busy = 1'b1;
    wb_xfer(1'b1, BASE, 32'h55, ra, rb, ack_ok, sel_seen);
    wb_xfer(1'b1, BASE, 32'hAA, ra, rb, ack_ok, sel_seen);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_tx_stb) begin
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_stb_while_busy: got busy=%b expected 0", tx_busy); end
        checks++; if (i - last < 3) begin errors++; $display("FAIL tx_stb_gap: got %0d expected >= 3", i - last); end
        if (nstb < 2) got[nstb] = a_tx_data;
        last = i;
        nstb++;
        pend = 10;
      end else if (pend > 0) begin
        tx_busy = 1'b1;
        pend--;
      end else begin
        tx_busy = 1'b0;
      end
    end
    checks++; if (nstb !== 2) begin errors++; $display("FAIL tx_stb_count: got %0d expected 2", nstb); end
    checks++; if (got[0] !== 8'h55 || got[1] !== 8'hAA) begin errors++; $display("FAIL tx_bytes: got %h %h expected 55 aa", got[0], got[1]); end
    wb_xfer(1'b0, BASE + 30'd1, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (ra !== 32'h0000_000A) begin errors++; $display("FAIL tx_drained_status: got %h expected 0000000a", ra); end
  endtask

  task automatic test_reset_mid_tx();
    int pend = 0;
    logic seen = 1'b0;
    apply_reset();
    tx_busy = 1'b1;
    wb_xfer(1'b1, BASE, 32'h11, ra, rb, ack_ok, sel_seen);
    wb_xfer(1'b1, BASE, 32'h22, ra, rb, ack_ok, sel_seen);
    wb_xfer(1'b1, BASE, 32'h33, ra, rb, ack_ok, sel_seen);
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (a_tx_stb) begin
        seen = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (a_tx_stb !== 1'b0) begin errors++; $display("FAIL async_reset_tx_stb: got %b expected 0", a_tx_stb); end
        checks++; if (a_ldr_reset !== 1'b1) begin errors++; $display("FAIL async_reset_ldr_reset: got %b expected 1", a_ldr_reset); end
      end else if (pend > 0) begin
        tx_busy = 1'b1;
        pend--;
      end else begin
        tx_busy = 1'b0;
      end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_tx_strobe_timeout: got %b expected 1", seen); end
    @(negedge clk);
    rst = 1'b0;
    tx_busy = 1'b0;
    wb_xfer(1'b0, BASE + 30'd1, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (ra !== 32'h0000_000A || rb !== 32'h0000_000B) begin errors++; $display("FAIL post_reset_status: got %h/%h expected 0000000a/0000000b", ra, rb); end
  endtask

  task automatic test_tx_collision();
    logic seen = 1'b0;
    apply_reset();
    tx_busy = 1'b1;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = BASE; wb_wdata = 32'h5A;
    ldr_tx_stb = 1'b1; ldr_tx_data = 8'hC3;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; ldr_tx_stb = 1'b0;
    wb_xfer(1'b0, BASE + 30'd1, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (ra !== 32'h0001_0042) begin errors++; $display("FAIL collision_status_a: got %h expected 00010042", ra); end
    checks++; if (rb !== 32'h0001_0003) begin errors++; $display("FAIL collision_status_b: got %h expected 00010003", rb); end
    tx_busy = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (a_tx_stb) begin
        seen = 1'b1;
        checks++; if (a_tx_data !== 8'h5A) begin errors++; $display("FAIL collision_winner: got %h expected 5a", a_tx_data); end
      end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL collision_strobe_timeout: got %b expected 1", seen); end
    wb_xfer(1'b1, BASE + 30'd1, 32'h4, ra, rb, ack_ok, sel_seen);
    wb_xfer(1'b0, BASE + 30'd1, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (ra !== 32'h0000_000A) begin errors++; $display("FAIL ovf_cleared_status: got %h expected 0000000a", ra); end
  endtask

  task automatic test_unmapped();
    apply_reset();
    wb_xfer(1'b0, BASE + 30'd3, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (ra !== 32'h0 || sel_seen !== 1'b0 || ack_ok !== 1'b1) begin errors++; $display("FAIL unmapped_above: got data=%h sel=%b ack_ok=%b expected 0 0 1", ra, sel_seen, ack_ok); end
    wb_xfer(1'b0, BASE - 30'd1, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (ra !== 32'h0 || sel_seen !== 1'b0 || ack_ok !== 1'b1) begin errors++; $display("FAIL unmapped_below: got data=%h sel=%b ack_ok=%b expected 0 0 1", ra, sel_seen, ack_ok); end
    wb_xfer(1'b1, BASE + 30'd3, 32'hFF, ra, rb, ack_ok, sel_seen);
    wb_xfer(1'b0, BASE + 30'd1, 32'h0, ra, rb, ack_ok, sel_seen);
    checks++; if (ra !== 32'h0000_000A) begin errors++; $display("FAIL unmapped_write_ignored: got %h expected 0000000a", ra); end
  endtask

  initial begin
    test_reset();
    test_loader_forward();
    test_bus_fifo();
    test_overflow_and_same_cycle();
    test_tx_stream();
    test_reset_mid_tx();
    test_tx_collision();
    test_unmapped();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
